// File: rtl/riscv_uart_loader_pkg.sv
// Shared definitions for the UART program loader.
// Contents:
//   - loader FSM state encodings (LDR_*)
//   - frame target codes (LDR_TGT_INST / LDR_TGT_DATA)
//   - UART receiver state encodings (RX_*)
//   - ldr_holds_core(): states in which the core is stalled and a frame is in progress
package riscv_uart_loader_pkg;

  localparam logic [2:0] LDR_IDLE  = 3'd0;
  localparam logic [2:0] LDR_TGT   = 3'd1;
  localparam logic [2:0] LDR_CNT0  = 3'd2;
  localparam logic [2:0] LDR_CNT1  = 3'd3;
  localparam logic [2:0] LDR_DATA  = 3'd4;
  localparam logic [2:0] LDR_WRITE = 3'd5;
  localparam logic [2:0] LDR_DONE  = 3'd6;
  localparam logic [2:0] LDR_ERR   = 3'd7;

  localparam logic [7:0] LDR_TGT_INST = 8'h00;
  localparam logic [7:0] LDR_TGT_DATA = 8'h01;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // True while a frame is being received: the core is held, the idle-gap
  // timer runs and a framing error aborts the load.
  function automatic logic ldr_holds_core(input logic [2:0] s);
    return (s == LDR_TGT) || (s == LDR_CNT0) || (s == LDR_CNT1) ||
           (s == LDR_DATA) || (s == LDR_WRITE);
  endfunction

endpackage

// File: rtl/riscv_uart_loader_if.sv
// Memory write port driven by the loader into the core's memory mux.
// Signals:
//   mem_we     one-cycle write strobe
//   mem_sel    0 = instruction memory, 1 = data memory
//   mem_addr   word address (ADDR_W bits)
//   mem_wdata  32-bit write data
// Handshake: mem_we is a pure strobe with no ready/back-pressure. The memory
// must accept the write in the cycle mem_we is high; mem_sel, mem_addr and
// mem_wdata are only meaningful in that cycle.
interface riscv_uart_loader_if #(
  parameter int ADDR_W = 14
);
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (output mem_we, output mem_sel, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_sel, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/riscv_uart_loader_uart_rx_byte.sv
// 8N1 UART byte receiver.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   rx            asynchronous serial line, idle high
//   byte_valid    1-cycle pulse, byte_data holds the received byte
//   byte_data     last good byte (LSB received first)
//   framing_err   1-cycle pulse when the stop bit samples low (byte dropped)
//   rx_state      receiver FSM state (RX_*)
module uart_rx_byte
  import riscv_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err,
  output logic [1:0] rx_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [1:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  assign rx_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Line idles high, so the synchroniser resets high to avoid a false start.
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= RX_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      framing_err <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state   <= RX_START;
            clk_cnt <= '0;
          end
        end
        RX_START: begin
          // Half a bit after the edge: still low means a real start bit.
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            state   <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              framing_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/riscv_uart_loader.sv
// UART program loader: holds the core, receives a framed image over rx and
// writes it word by word into instruction or data memory, then restarts the core.
// Frame: TGT (00 instr / 01 data), CNT_L, CNT_H (word count N), N x 4 bytes LE.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   start_pg       level input; a rising edge arms (or re-arms) a load
//   rx             UART line, 8N1, idle high
//   cpu_hold       high while a frame is being received
//   cpu_restart    one-cycle pulse after a successful load
//   mem            memory write port (master side)
//   load_done      sticky success flag, cleared on arm
//   load_err       sticky error flag, cleared on arm
//   dbg_state      loader FSM state (LDR_*)
//   dbg_rx_state   UART receiver FSM state (RX_*)
module riscv_uart_loader
  import riscv_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 180,
  parameter int TIMEOUT_CYCLES = 2_300_000,
  parameter int ADDR_W         = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_pg,
  input  logic                       rx,
  output logic                       cpu_hold,
  output logic                       cpu_restart,
  riscv_uart_loader_if.master        mem,
  output logic                       load_done,
  output logic                       load_err,
  output logic [2:0]                 dbg_state,
  output logic [1:0]                 dbg_rx_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  // The 16-bit count can never exceed the memory when ADDR_W >= 16.
  localparam int unsigned MAX_WORDS = (ADDR_W >= 16) ? 32'd65536 : (32'd1 << ADDR_W);
  // Index must be able to reach N (up to 2^16) without wrapping.
  localparam int IDX_W = (ADDR_W > 16) ? ADDR_W : 17;

  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             framing_err;

  logic             start_meta;
  logic             start_sync;
  logic             start_prev;
  logic             arm;

  logic [2:0]       state;
  logic             sel_r;
  logic [7:0]       cnt_l;
  logic [15:0]      n_words;
  logic [15:0]      count_n;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [1:0]       lane;
  logic [31:0]      word;
  logic [TO_W-1:0]  idle_cnt;
  logic             holding;
  logic             timeout_hit;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .framing_err (framing_err),
    .rx_state    (dbg_rx_state)
  );

  assign arm         = start_sync & ~start_prev;
  assign count_n     = {byte_data, cnt_l};
  assign idx_next    = idx + 1'b1;
  assign holding     = ldr_holds_core(state);
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = holding && (idle_cnt == TO_LAST) && !byte_valid;

  assign cpu_hold      = holding;
  assign cpu_restart   = (state == LDR_DONE);
  assign dbg_state     = state;
  assign mem.mem_we    = (state == LDR_WRITE);
  assign mem.mem_sel   = sel_r;
  assign mem.mem_addr  = idx[ADDR_W-1:0];
  assign mem.mem_wdata = word;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
      state      <= LDR_IDLE;
      sel_r      <= 1'b0;
      cnt_l      <= '0;
      n_words    <= '0;
      idx        <= '0;
      lane       <= '0;
      word       <= '0;
      idle_cnt   <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      start_meta <= start_pg;
      start_sync <= start_meta;
      start_prev <= start_sync;

      if (arm || byte_valid || !holding) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TO_LAST) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (arm) begin
        // Also aborts a load in progress; words already written stay written.
        state     <= LDR_TGT;
        load_done <= 1'b0;
        load_err  <= 1'b0;
        idx       <= '0;
        lane      <= '0;
      end else if ((framing_err && holding) || timeout_hit) begin
        state    <= LDR_ERR;
        load_err <= 1'b1;
      end else begin
        case (state)
          LDR_TGT: begin
            if (byte_valid) begin
              if (byte_data == LDR_TGT_INST || byte_data == LDR_TGT_DATA) begin
                sel_r <= byte_data[0];
                state <= LDR_CNT0;
              end else begin
                state    <= LDR_ERR;
                load_err <= 1'b1;
              end
            end
          end
          LDR_CNT0: begin
            if (byte_valid) begin
              cnt_l <= byte_data;
              state <= LDR_CNT1;
            end
          end
          LDR_CNT1: begin
            if (byte_valid) begin
              n_words <= count_n;
              if (count_n == 16'd0) begin
                state     <= LDR_DONE;
                load_done <= 1'b1;
              end else if (32'(count_n) > MAX_WORDS) begin
                state    <= LDR_ERR;
                load_err <= 1'b1;
              end else begin
                state <= LDR_DATA;
                idx   <= '0;
                lane  <= '0;
              end
            end
          end
          LDR_DATA: begin
            if (byte_valid) begin
              // Little-endian: after four shifts the first byte sits in [7:0].
              word <= {byte_data, word[31:8]};
              lane <= lane + 2'd1;
              if (lane == 2'd3) begin
                state <= LDR_WRITE;
              end
            end
          end
          LDR_WRITE: begin
            idx <= idx_next;
            if (idx_next == IDX_W'(n_words)) begin
              state     <= LDR_DONE;
              load_done <= 1'b1;
            end else begin
              state <= LDR_DATA;
            end
          end
          LDR_DONE: state <= LDR_IDLE;
          LDR_ERR:  state <= LDR_IDLE;
          default:  state <= LDR_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_uart_loader.sv
// Bench for riscv_uart_loader: directed frames from the test plan plus random
// frames, checked against a frame-level reference model.
module tb_riscv_uart_loader;
  import riscv_uart_loader_pkg::*;

  localparam int CPB      = 8;
  localparam int TO       = 1500;
  localparam int AW       = 4;
  localparam int W        = 1 + AW + 32;
  localparam int OUT_DONE = 1;
  localparam int OUT_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_pg;
  logic        rx;
  logic        cpu_hold;
  logic        cpu_restart;
  logic        load_done;
  logic        load_err;
  logic [2:0]  dbg_state;
  logic [1:0]  dbg_rx_state;

  riscv_uart_loader_if #(.ADDR_W(AW)) mem_bus ();

  riscv_uart_loader #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TO),
    .ADDR_W         (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_pg     (start_pg),
    .rx           (rx),
    .cpu_hold     (cpu_hold),
    .cpu_restart  (cpu_restart),
    .mem          (mem_bus.master),
    .load_done    (load_done),
    .load_err     (load_err),
    .dbg_state    (dbg_state),
    .dbg_rx_state (dbg_rx_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]  frame_q[$];
  int          restart_cnt = 0;
  int          extra_we    = 0;
  int          hold_low    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the next expected write, in order.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      if (cpu_restart) restart_cnt++;
      if (mem_bus.mem_we) begin
        if (exp_q.size() == 0) begin
          extra_we++;
        end else begin
          e = exp_q.pop_front();
          check("mem_write", 64'({mem_bus.mem_sel, mem_bus.mem_addr, mem_bus.mem_wdata}), 64'(e));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Parses frame_q as a whole frame; queues the writes it implies and returns
  // the outcome. A frame that stops short of its declared length ends in error.
  function automatic int model_frame();
    int n;
    if (frame_q.size() < 1) return OUT_ERR;
    if (frame_q[0] > 8'h01) return OUT_ERR;
    if (frame_q.size() < 3) return OUT_ERR;
    n = int'(frame_q[1]) | (int'(frame_q[2]) << 8);
    if (n == 0) return OUT_DONE;
    if (n > (1 << AW)) return OUT_ERR;
    for (int w = 0; w < n; w++) begin
      if (frame_q.size() < 3 + 4 * (w + 1)) return OUT_ERR;
      exp_q.push_back({frame_q[0][0], AW'(w),
                       frame_q[6 + 4 * w], frame_q[5 + 4 * w],
                       frame_q[4 + 4 * w], frame_q[3 + 4 * w]});
    end
    return OUT_DONE;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic arm();
    @(negedge clk);
    start_pg = 1'b1;
    repeat (6) @(negedge clk);
    check("hold_on_arm", 64'(cpu_hold), 64'(1));
    check("done_cleared", 64'(load_done), 64'(0));
    check("err_cleared", 64'(load_err), 64'(0));
    start_pg = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero();
    check("rst_hold", 64'(cpu_hold), 64'(0));
    check("rst_restart", 64'(cpu_restart), 64'(0));
    check("rst_we", 64'(mem_bus.mem_we), 64'(0));
    check("rst_sel", 64'(mem_bus.mem_sel), 64'(0));
    check("rst_addr", 64'(mem_bus.mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_bus.mem_wdata), 64'(0));
    check("rst_done", 64'(load_done), 64'(0));
    check("rst_err", 64'(load_err), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(LDR_IDLE));
  endtask

  // mode 0: send frame_q; 1: then a byte with a low stop bit; 2: then go silent.
  task automatic run_frame(input int mode);
    int exp_out;
    int waited;
    exp_q.delete();
    exp_out = model_frame();
    if (mode != 0) exp_out = OUT_ERR;
    restart_cnt = 0;
    extra_we    = 0;
    hold_low    = 0;
    arm();
    foreach (frame_q[i]) begin
      if (!cpu_hold) hold_low++;
      send_byte(frame_q[i], 1'b1);
    end
    if (mode == 1) begin
      if (!cpu_hold) hold_low++;
      send_byte(8'($urandom_range(0, 255)), 1'b0);
    end
    waited = 0;
    while (!(load_done || load_err) && waited < 3 * TO) begin
      @(negedge clk);
      waited++;
    end
    check("finish_in_time", 64'(waited < 3 * TO), 64'(1));
    repeat (4) @(negedge clk);
    check("load_done", 64'(load_done), 64'(exp_out == OUT_DONE));
    check("load_err", 64'(load_err), 64'(exp_out == OUT_ERR));
    check("restart_pulses", 64'(restart_cnt), 64'((exp_out == OUT_DONE) ? 1 : 0));
    check("hold_released", 64'(cpu_hold), 64'(0));
    check("hold_gaps", 64'(hold_low), 64'(0));
    check("writes_missing", 64'(exp_q.size()), 64'(0));
    check("writes_extra", 64'(extra_we), 64'(0));
    check("state_idle", 64'(dbg_state), 64'(LDR_IDLE));
  endtask

  task automatic fill_words(input int n);
    for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] tgt;
    int         n;
    rst      = 1'b1;
    start_pg = 1'b0;
    rx       = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero();
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Two instruction words.
    frame_q = '{8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
    run_frame(0);

    // Empty data image.
    frame_q = '{8'h01, 8'h00, 8'h00};
    run_frame(0);

    // Bad target byte.
    frame_q = '{8'h05};
    run_frame(0);

    // Silence mid-word: timeout, nothing written.
    frame_q = '{8'h00, 8'h01, 8'h00, 8'h13, 8'h00};
    run_frame(2);

    // Framing error in the CNT0 position, then a clean load clears the flag.
    frame_q = '{8'h00};
    run_frame(1);
    frame_q = '{8'h00, 8'h01, 8'h00};
    fill_words(1);
    run_frame(0);

    // Count boundaries: exactly the memory size, one more, and a high count byte.
    frame_q = '{8'h01, 8'((1 << AW) & 8'hff), 8'(((1 << AW) >> 8) & 8'hff)};
    fill_words(1 << AW);
    run_frame(0);
    frame_q = '{8'h00, 8'(((1 << AW) + 1) & 8'hff), 8'((((1 << AW) + 1) >> 8) & 8'hff)};
    run_frame(0);
    frame_q = '{8'h01, 8'h00, 8'h01};
    run_frame(0);

    // Re-arm mid-frame aborts the partial load and starts over.
    arm();
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'haa, 1'b1);
    frame_q = '{8'h01, 8'h02, 8'h00};
    fill_words(2);
    run_frame(0);

    // Reset while in DATA, then a full load from address 0.
    arm();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    check("in_data", 64'(dbg_state), 64'(LDR_DATA));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    frame_q = '{8'h00, 8'h03, 8'h00};
    fill_words(3);
    run_frame(0);

    // Random frames, occasionally with a bad target.
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        tgt = 8'($urandom_range(2, 255));
        frame_q = '{tgt};
      end else begin
        tgt = 8'($urandom_range(0, 1));
        n   = $urandom_range(1, 6);
        frame_q = '{tgt, 8'(n), 8'h00};
        fill_words(n);
      end
      run_frame(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_uart_loader.md
Name: riscv_uart_loader

Overview:
- UART programming controller that sequences the CPU's instruction and data memories while a program image is downloaded over rx.
- On start_pg it holds the CPU and receives a framed image (8N1 UART). It assembles little-endian 32-bit words and issues one-cycle memory write strobes, then releases the CPU with a restart pulse.
- Sits beside the core: its outputs drive the core hold/restart and the memory write-port mux select.

Parameters:
- CLKS_PER_BIT, 180, clk cycles per UART bit (23 MHz / 128000 baud).
- TIMEOUT_CYCLES, 2_300_000, idle-gap limit between bytes inside a frame (~100 ms).
- ADDR_W, 14, word-address width of each target memory.

Ports:
- clk  in  1  system clock (single clock domain).
- rst  in  1  synchronous, active-high reset.
- start_pg  in  1  level; a rising edge (synchronised internally) arms a load.
- rx  in  1  asynchronous UART line, idle high.
- cpu_hold  out  1  high while loading; the core stalls its pc and suppresses its own memory writes; the memory port is muxed to the loader.
- cpu_restart  out  1  one-cycle pulse on successful completion; the core resets its pc to 0.
- mem_we  out  1  one-cycle write strobe.
- mem_sel  out  1  0 = instruction memory, 1 = data memory.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- load_done  out  1  sticky success flag, cleared on next arm.
- load_err  out  1  sticky error flag, cleared on next arm.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- UART RX sub-block:
  - 2-flop synchroniser on rx.
  - Start bit is detected on a falling edge and confirmed low at CLKS_PER_BIT/2.
  - 8 data bits are sampled LSB first at bit centres.
  - Stop bit is sampled at its centre. If high: byte_valid pulses for 1 cycle with byte_data. If low: framing_err pulses instead and the byte is discarded.
- Frame format: TGT byte (0x00 instr, 0x01 data), CNT_L, CNT_H (16-bit word count N, LE), then N×4 data bytes, each word LE.
- FSM states: IDLE → TGT → CNT0 → CNT1 → DATA → WRITE → DONE / ERR.
  - IDLE: cpu_hold=0. A start_pg rising edge → TGT; cpu_hold=1 from the next cycle; load_done and load_err are cleared.
  - TGT: a byte of 0x00 or 0x01 latches mem_sel → CNT0. Any other value → ERR.
  - CNT0/CNT1: latch the count. At CNT1, N=0 → DONE. N > 2^ADDR_W → ERR. Otherwise → DATA with word index 0 and byte lane 0.
  - DATA: each byte shifts into lane 0..3. When lane 3 is received → WRITE.
  - WRITE: exactly 1 cycle with mem_we=1, mem_addr=index, mem_wdata=assembled word. Then index+1; if index+1==N → DONE, else → DATA.
  - DONE: cpu_restart=1 for 1 cycle, load_done=1, cpu_hold=0 → IDLE.
  - ERR: load_err=1, cpu_hold=0, no restart → IDLE.
- Latency: mem_we asserts 1 cycle after the byte_valid of lane 3. The restart pulse comes 1 cycle after the final WRITE.
- Timeout: in TGT through DATA, an idle counter resets on every byte_valid. Reaching TIMEOUT_CYCLES → ERR. The counter is inactive in IDLE.
- A framing_err in any non-IDLE state → ERR. Bytes received in IDLE are ignored.
- A start_pg rising edge while not in IDLE aborts and restarts at TGT. Flags are cleared and already-written words are not undone.
- A byte_valid coincident with a timeout expiry: the byte wins and the counter resets.
- Word index wraps never; it is bounded by the N check.
- rst asserted mid-frame returns the block to IDLE with every output 0 on the next edge. The core is then not held, and memory content is undefined.

Decomposition:
- Shared defines file (alongside the existing core defines):
  - loader state encodings: LDR_IDLE, LDR_TGT, LDR_CNT0, LDR_CNT1, LDR_DATA, LDR_WRITE, LDR_DONE, LDR_ERR;
  - target codes LDR_TGT_INST=8'h00 and LDR_TGT_DATA=8'h01.
- One sub-module, uart_rx_byte: synchroniser, bit timer and shift register; outputs byte_valid, byte_data, framing_err.

Test Plan:
- Arm with start_pg, then send 00 02 00 | 13 00 00 00 | 93 00 10 00 → mem_we twice: (sel 0, addr 0, 0x00000013), then (sel 0, addr 1, 0x00100093). Then cpu_restart pulses once and load_done=1; cpu_hold is high from arm until DONE.
- Send 01 00 00 → no mem_we; cpu_restart pulses; load_done=1.
- Send 05 as the target byte → load_err=1, no mem_we, no restart, cpu_hold=0.
- Send 00 01 00 13 00, then go silent → after TIMEOUT_CYCLES load_err=1 and no write occurs.
- Send a byte with stop bit 0 in the CNT0 position → load_err=1. Then re-arm and send a valid frame → load_err clears and the load completes.
- Assert rst during the DATA state, then deassert → all outputs 0 and the FSM in IDLE. A subsequent arm and valid frame loads correctly from addr 0.
